// File: rtl/bw_icache_fill_pkg.sv
// bw_icache_fill_pkg: shared types and constants for the I-cache line-fill controller.
//   state_t    : fill FSM states
//   LINE_BYTES : bytes per cache line
//   LINE_OFF_W : byte-offset width within a line (line address = addr[AWID-1:LINE_OFF_W])
//   LINE_IDX_* : line-index slice used by the valid array
//   line_t     : one assembled 512-bit line
package bw_icache_fill_pkg;

    localparam int unsigned LINE_BYTES  = 64;
    localparam int unsigned LINE_BITS   = LINE_BYTES * 8;
    localparam int unsigned LINE_OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned LINE_IDX_LO = 6;
    localparam int unsigned LINE_IDX_HI = 12;

    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

endpackage

// File: rtl/bw_icache_fill_linebuf.sv
// bw_icache_fill_linebuf: beat-slot register file that assembles one cache line.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (clears the line)
//   we         : write the beat on din into slot idx
//   idx        : beat slot index
//   din        : beat data (DWID bits)
//   line_o     : assembled line; holds its contents until overwritten
module bw_icache_fill_linebuf
    import bw_icache_fill_pkg::*;
#(
    parameter int unsigned DWID       = 128,
    parameter int unsigned LINE_BEATS = 4,
    parameter int unsigned IDX_W      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [DWID-1:0]  din,
    output line_t            line_o
);

    // One slot written per accepted beat; other slots keep their data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_o <= '0;
        end else if (we) begin
            for (int unsigned i = 0; i < LINE_BEATS; i++) begin
                if (idx == IDX_W'(i)) begin
                    line_o[i*DWID +: DWID] <= din;
                end
            end
        end
    end

endmodule

// File: rtl/bw_icache_fill.sv
// bw_icache_fill: instruction-cache line-fill controller.
// On a fetch miss it bursts one 64-byte line from memory, assembles it and
// issues a single-cycle write/set-valid to the I-cache. Invalidations that hit
// the line being filled force a refetch so a stale line is never marked valid.
// Optional feature macro: BW_ICFILL_CRITWORD_EN (critical-word-first burst,
// adds output crit_vld).
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   miss, miss_adr  : fetch miss request and physical address
//   busy            : controller not idle
//   req, req_adr    : memory burst request and current beat address
//   ack, dat_i, err : beat accepted, beat data, bus error
//   invce, invline, invall, inv_adr : invalidation snoop
//   wr, way, ip     : line write / set-valid strobe, way, line address
//   line_o          : assembled line
//   done, fault     : completion pulse, bus-error pulse
//   crit_vld        : (feature build only) critical beat delivered
module bw_icache_fill
    import bw_icache_fill_pkg::*;
#(
    parameter int unsigned AWID       = 32,
    parameter int unsigned DWID       = 128,
    parameter int unsigned LINE_BEATS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             miss,
    input  logic [AWID-1:0]  miss_adr,
    output logic             busy,
    output logic             req,
    output logic [AWID-1:0]  req_adr,
    input  logic             ack,
    input  logic [DWID-1:0]  dat_i,
    input  logic             err,
    input  logic             invce,
    input  logic             invline,
    input  logic             invall,
    input  logic [AWID-1:0]  inv_adr,
    output logic             wr,
    output logic [1:0]       way,
    output logic [AWID-1:0]  ip,
    output line_t            line_o,
    output logic             done,
    output logic             fault
`ifdef BW_ICFILL_CRITWORD_EN
    ,
    output logic             crit_vld
`endif
);

    localparam int unsigned BYTE_W = $clog2(DWID / 8);
    localparam int unsigned BEAT_W = $clog2(LINE_BEATS);
    localparam int unsigned TAG_W  = AWID - LINE_OFF_W;

    state_t              state;
    state_t              state_nx;
    logic [TAG_W-1:0]    line_tag;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   beat_start;
    logic [BEAT_W-1:0]   cnt;
    logic                stale;
    logic [1:0]          rr;

    logic                inv_hit_c;
    logic                beat_ok_c;
    logic                last_c;
    logic                refetch_c;
    logic [BEAT_W-1:0]   first_beat_c;
    logic                unused_adr_bits;

    // Beat at which a new burst starts.
`ifdef BW_ICFILL_CRITWORD_EN
    assign first_beat_c = miss_adr[LINE_OFF_W-1:BYTE_W];
`else
    assign first_beat_c = '0;
`endif

    assign unused_adr_bits = ^{miss_adr[LINE_OFF_W-1:0], inv_adr[LINE_OFF_W-1:0]};

    // Invalidation hitting the line currently being filled.
    assign inv_hit_c = invce & (invall | (invline & (inv_adr[AWID-1:LINE_OFF_W] == line_tag)));
    assign beat_ok_c = (state == ST_REQ) & ack & ~err;
    assign last_c    = (cnt == BEAT_W'(LINE_BEATS - 1));
    // The valid array lets wr win over invalidation, so any hit must kill wr.
    assign refetch_c = stale | inv_hit_c;

    assign req_adr = {line_tag, beat, BYTE_W'(0)};
    assign ip      = {line_tag, LINE_OFF_W'(0)};
    assign way     = rr;

`ifdef BW_ICFILL_CRITWORD_EN
    // The first accepted beat of a burst is always the critical one.
    assign crit_vld = beat_ok_c & (cnt == '0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nx = state;
        busy     = (state != ST_IDLE);
        req      = 1'b0;
        wr       = 1'b0;
        done     = 1'b0;
        fault    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (miss) begin
                    state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                req = 1'b1;
                if (ack) begin
                    if (err) begin
                        state_nx = ST_ERR;
                    end else if (last_c) begin
                        state_nx = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (refetch_c) begin
                    state_nx = ST_REQ;
                end else begin
                    wr       = 1'b1;
                    done     = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_ERR: begin
                fault    = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Burst address, beat count, stale tracking and round-robin way.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_tag   <= '0;
            beat       <= '0;
            beat_start <= '0;
            cnt        <= '0;
            stale      <= 1'b0;
            rr         <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss) begin
                        line_tag   <= miss_adr[AWID-1:LINE_OFF_W];
                        beat       <= first_beat_c;
                        beat_start <= first_beat_c;
                        cnt        <= '0;
                        stale      <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (inv_hit_c) begin
                        stale <= 1'b1;
                    end
                    if (beat_ok_c) begin
                        beat <= beat + BEAT_W'(1);
                        cnt  <= cnt + BEAT_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (refetch_c) begin
                        beat  <= beat_start;
                        cnt   <= '0;
                        stale <= 1'b0;
                    end else begin
                        rr <= rr + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    bw_icache_fill_linebuf #(
        .DWID       (DWID),
        .LINE_BEATS (LINE_BEATS),
        .IDX_W      (BEAT_W)
    ) u_linebuf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (beat_ok_c),
        .idx    (beat),
        .din    (dat_i),
        .line_o (line_o)
    );

endmodule
